// File: rtl/xtimer_pkg.sv
// Shared definitions for the xtimer peripheral: bus geometry, register map,
// CTRL/STATUS bit positions and the timer FSM state type.
package xtimer_pkg;

    localparam logic [31:0] TIMER_BASE   = 32'h0000_1000;
    localparam int          TIMER_ADDR_W = 2;

    localparam logic [TIMER_ADDR_W-1:0] TIMER_CTRL   = 2'd0;
    localparam logic [TIMER_ADDR_W-1:0] TIMER_LOAD   = 2'd1;
    localparam logic [TIMER_ADDR_W-1:0] TIMER_COUNT  = 2'd2;
    localparam logic [TIMER_ADDR_W-1:0] TIMER_STATUS = 2'd3;

    localparam int CTRL_START     = 0;
    localparam int CTRL_STOP      = 1;
    localparam int CTRL_AUTO      = 2;
    localparam int STATUS_EXPIRED = 0;
    localparam int STATUS_RUNNING = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/xtimer_prescaler.sv
// Tick generator for xtimer: one-cycle tick every PRESC_DIV enabled cycles.
// Dropping en clears the phase so every enable period starts from zero.
module xtimer_prescaler #(
    parameter int PRESC_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESC_DIV - 1);

    logic [PW-1:0] cnt_r;

    assign tick = en && (cnt_r == LAST);

    // Phase counter: runs only while enabled, wraps after the tick cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= PW'(0);
        end else if (!en || tick) begin
            cnt_r <= PW'(0);
        end else begin
            cnt_r <= cnt_r + PW'(1);
        end
    end

endmodule

// File: rtl/xtimer.sv
// Memory-mapped prescaled up-counter with compare, expiry flag and level irq.
// Optional feature macro: XTIMER_AUTORELOAD_EN (CTRL bit 2 = periodic mode).
module xtimer
    import xtimer_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int PRESC_DIV = 100,
    parameter int DATA_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel,
    input  logic                    we,
    input  logic [TIMER_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]       data_in,
    output logic [DATA_W-1:0]       data_out,
    output logic                    irq
);

    state_e             state_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   load_r;
    logic               expired_r;
    logic               auto_s;
    logic               wr_s;
    logic               ctrl_wr_s;
    logic               start_s;
    logic               stop_s;
    logic               clr_s;
    logic               presc_en_s;
    logic               tick_s;
    logic               match_s;
    logic               unused_s;

    assign wr_s      = sel && we;
    assign ctrl_wr_s = wr_s && (addr == TIMER_CTRL);
    assign stop_s    = ctrl_wr_s && data_in[CTRL_STOP];
    assign start_s   = ctrl_wr_s && data_in[CTRL_START] && !data_in[CTRL_STOP];
    assign clr_s     = wr_s && (addr == TIMER_STATUS) && data_in[STATUS_EXPIRED];
    assign unused_s  = ^data_in;

    // Any start or stop resets the prescaler phase, as does leaving RUN
    assign presc_en_s = (state_r == ST_RUN) && !start_s && !stop_s;
    assign match_s    = (state_r == ST_RUN) && tick_s && (count_r == load_r);
    assign irq        = expired_r;

    xtimer_prescaler #(
        .PRESC_DIV (PRESC_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en_s),
        .tick (tick_s)
    );

`ifdef XTIMER_AUTORELOAD_EN
    logic auto_r;

    // Autoreload mode bit follows every CTRL write
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            auto_r <= data_in[CTRL_AUTO];
        end else begin
            auto_r <= auto_r;
        end
    end

    assign auto_s = auto_r;
`else
    assign auto_s = 1'b0;
`endif

    // Timer FSM, COUNT/LOAD registers and expiry flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            count_r   <= CNT_W'(0);
            load_r    <= CNT_W'(0);
            expired_r <= 1'b0;
        end else begin
            if (wr_s && (addr == TIMER_LOAD)) begin
                load_r <= data_in[CNT_W-1:0];
            end

            // Expiry beats a same-cycle clear
            if (match_s) begin
                expired_r <= 1'b1;
            end else if (clr_s) begin
                expired_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_s) begin
                        state_r <= ST_RUN;
                        count_r <= CNT_W'(0);
                    end
                end
                ST_RUN: begin
                    if (start_s) begin
                        count_r <= CNT_W'(0);
                    end else if (match_s) begin
                        if (auto_s) begin
                            count_r <= CNT_W'(0);
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end else if (tick_s) begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            if (stop_s) begin
                state_r <= ST_IDLE;
            end
        end
    end

    // Register read mux; unused bits read as zero
    always_comb begin
        data_out = {DATA_W{1'b0}};
        case (addr)
            TIMER_CTRL:   data_out[CTRL_AUTO] = auto_s;
            TIMER_LOAD:   data_out[CNT_W-1:0] = load_r;
            TIMER_COUNT:  data_out[CNT_W-1:0] = count_r;
            TIMER_STATUS: begin
                data_out[STATUS_EXPIRED] = expired_r;
                data_out[STATUS_RUNNING] = (state_r == ST_RUN);
            end
            default:      data_out = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_xtimer.sv
// Directed bench for xtimer: table of write/wait/read vectors plus hand-written
// sequences for expiry latency, LOAD change during RUN, reset and autoreload.
module tb_xtimer;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic        sel0, sel1, sel2;
    logic [31:0] dout0, dout1;
    logic        irq0, irq1;
`ifdef XTIMER_AUTORELOAD_EN
    logic [31:0] dout2;
    logic        irq2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          tgt;
        bit          wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        int          idle;
        logic [1:0]  raddr;
        logic [31:0] exp_data;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    xtimer #(.CNT_W(32), .PRESC_DIV(4), .DATA_W(32)) dut4 (
        .clk(clk), .rst(rst), .sel(sel0), .we(we), .addr(addr),
        .data_in(data_in), .data_out(dout0), .irq(irq0)
    );

    xtimer #(.CNT_W(32), .PRESC_DIV(1), .DATA_W(32)) dut1 (
        .clk(clk), .rst(rst), .sel(sel1), .we(we), .addr(addr),
        .data_in(data_in), .data_out(dout1), .irq(irq1)
    );

`ifdef XTIMER_AUTORELOAD_EN
    xtimer #(.CNT_W(32), .PRESC_DIV(2), .DATA_W(32)) dut2 (
        .clk(clk), .rst(rst), .sel(sel2), .we(we), .addr(addr),
        .data_in(data_in), .data_out(dout2), .irq(irq2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_sel(input int tgt, input logic v);
        sel0 = (tgt == 0) ? v : 1'b0;
        sel1 = (tgt == 1) ? v : 1'b0;
        sel2 = (tgt == 2) ? v : 1'b0;
    endtask

    task automatic do_write(input int tgt, input logic [1:0] a, input logic [31:0] d);
        set_sel(tgt, 1'b1);
        we      = 1'b1;
        addr    = a;
        data_in = d;
        step(1);
        set_sel(tgt, 1'b0);
        we      = 1'b0;
    endtask

    task automatic check(input int tgt, input logic [1:0] ra, input logic [31:0] exp_d,
                         input logic exp_i, input int id);
        logic [31:0] got_d;
        logic        got_i;
        addr = ra;
        #1;
        got_d = 32'd0;
        got_i = 1'b0;
        case (tgt)
            0: begin got_d = dout0; got_i = irq0; end
            1: begin got_d = dout1; got_i = irq1; end
`ifdef XTIMER_AUTORELOAD_EN
            2: begin got_d = dout2; got_i = irq2; end
`endif
            default: begin got_d = 32'hDEAD_BEEF; got_i = 1'bx; end
        endcase
        n_checks++;
        if (got_d !== exp_d || got_i !== exp_i) begin
            n_fail++;
            $display("FAIL chk%0d dut%0d addr%0d: got data=%h irq=%b, expected data=%h irq=%b",
                     id, tgt, ra, got_d, got_i, exp_d, exp_i);
        end
    endtask

    task automatic add(input int tgt, input bit wr, input logic [1:0] wa, input logic [31:0] wd,
                       input int idle, input logic [1:0] ra, input logic [31:0] ed, input logic ei);
        vec_t v;
        v.tgt = tgt; v.wr = wr; v.waddr = wa; v.wdata = wd;
        v.idle = idle; v.raddr = ra; v.exp_data = ed; v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        rst = 1'b1; we = 1'b0; addr = 2'd0; data_in = 32'd0;
        sel0 = 1'b0; sel1 = 1'b0; sel2 = 1'b0;

        // dut4: PRESC_DIV=4
        add(0, 0, 2'd0, 32'd0,  0, 2'd0, 32'd0, 1'b0);  // reset values
        add(0, 0, 2'd0, 32'd0,  0, 2'd1, 32'd0, 1'b0);
        add(0, 0, 2'd0, 32'd0,  0, 2'd2, 32'd0, 1'b0);
        add(0, 0, 2'd0, 32'd0,  0, 2'd3, 32'd0, 1'b0);
        add(0, 1, 2'd1, 32'd3,  0, 2'd1, 32'd3, 1'b0);
        add(0, 1, 2'd0, 32'd1, 15, 2'd3, 32'd2, 1'b0);  // 15 cycles: still running
        add(0, 0, 2'd0, 32'd0,  1, 2'd3, 32'd1, 1'b1);  // 16 cycles: expired, DONE
        add(0, 0, 2'd0, 32'd0,  0, 2'd2, 32'd3, 1'b1);
        add(0, 0, 2'd0, 32'd0,  5, 2'd2, 32'd3, 1'b1);  // held in DONE
        add(0, 1, 2'd3, 32'd1,  0, 2'd3, 32'd0, 1'b0);  // clear
        add(0, 1, 2'd0, 32'd1, 15, 2'd3, 32'd2, 1'b0);  // restart from DONE
        add(0, 1, 2'd3, 32'd1,  0, 2'd3, 32'd1, 1'b1);  // clear on expiry edge: set wins
        add(0, 1, 2'd3, 32'd1,  0, 2'd3, 32'd0, 1'b0);
        add(0, 1, 2'd1, 32'd10, 0, 2'd1, 32'd10, 1'b0);
        add(0, 1, 2'd0, 32'd1, 20, 2'd2, 32'd5, 1'b0);  // five ticks
        add(0, 1, 2'd0, 32'd2,  0, 2'd3, 32'd0, 1'b0);  // stop
        add(0, 0, 2'd0, 32'd0,  8, 2'd2, 32'd5, 1'b0);  // COUNT held
        add(0, 1, 2'd0, 32'd3,  8, 2'd3, 32'd0, 1'b0);  // start+stop: stays IDLE
        add(0, 0, 2'd0, 32'd0,  0, 2'd2, 32'd5, 1'b0);
        add(0, 1, 2'd0, 32'd1,  9, 2'd2, 32'd2, 1'b0);
        add(0, 1, 2'd0, 32'd1,  3, 2'd2, 32'd0, 1'b0);  // restart clears COUNT and phase
        add(0, 0, 2'd0, 32'd0,  1, 2'd2, 32'd1, 1'b0);
        add(0, 0, 2'd0, 32'd0,  0, 2'd0, 32'd0, 1'b0);  // CTRL reads 0
        add(0, 1, 2'd0, 32'd2,  0, 2'd3, 32'd0, 1'b0);
        // dut1: PRESC_DIV=1, LOAD=0
        add(1, 1, 2'd0, 32'd1,  0, 2'd3, 32'd2, 1'b0);
        add(1, 0, 2'd0, 32'd0,  1, 2'd3, 32'd1, 1'b1);  // expires one cycle after start
        add(1, 1, 2'd3, 32'd1,  0, 2'd3, 32'd0, 1'b0);

        step(1);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) do_write(vecs[i].tgt, vecs[i].waddr, vecs[i].wdata);
            step(vecs[i].idle);
            check(vecs[i].tgt, vecs[i].raddr, vecs[i].exp_data, vecs[i].exp_irq, i);
        end

        // Expiry latency measured with a bounded wait
        do_write(0, 2'd1, 32'd3);
        do_write(0, 2'd0, 32'd1);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (irq0 === 1'b1) begin
                n = k;
                break;
            end
        end
        n_checks++;
        if (n != 16) begin
            n_fail++;
            $display("FAIL expiry_latency: got %0d cycles (0 = timeout), expected 16", n);
        end
        check(0, 2'd2, 32'd3, 1'b1, 200);

        // LOAD lowered during RUN takes effect from the next compare
        do_write(1, 2'd1, 32'd100);
        do_write(1, 2'd0, 32'd1);
        step(5);
        check(1, 2'd2, 32'd5, 1'b0, 201);
        do_write(1, 2'd1, 32'd7);
        check(1, 2'd2, 32'd6, 1'b0, 202);
        step(2);
        check(1, 2'd3, 32'd1, 1'b1, 203);
        check(1, 2'd2, 32'd7, 1'b1, 204);

        // Reset mid-RUN with expired still set
        do_write(1, 2'd0, 32'd1);
        step(3);
        check(1, 2'd3, 32'd3, 1'b1, 205);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            check(1, 2'(r), 32'd0, 1'b0, 210 + r);
            check(0, 2'(r), 32'd0, 1'b0, 220 + r);
        end

`ifdef XTIMER_AUTORELOAD_EN
        do_write(2, 2'd1, 32'd2);
        do_write(2, 2'd0, 32'd5);
        step(5);
        check(2, 2'd3, 32'd2, 1'b0, 230);
        step(1);
        check(2, 2'd3, 32'd3, 1'b1, 231);  // first expiry at 6 cycles
        check(2, 2'd0, 32'd4, 1'b1, 232);
        do_write(2, 2'd3, 32'd1);
        check(2, 2'd3, 32'd2, 1'b0, 233);
        step(4);
        check(2, 2'd3, 32'd2, 1'b0, 234);
        step(1);
        check(2, 2'd3, 32'd3, 1'b1, 235);  // second expiry 6 cycles later
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
